// File: rtl/shared_div_scheduler_if.sv
// Request/response bundle for shared_div_scheduler: NREQ requesters in, one result stream out.
interface shared_div_scheduler_if #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4
);
    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_dividend;
    logic [NREQ*WIDTH-1:0] req_divisor;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [WIDTH-1:0]      rsp_quotient;
    logic [WIDTH-1:0]      rsp_remainder;
    logic [IDW-1:0]        rsp_id;
    logic                  rsp_divzero;

    modport master (
        output req_valid, req_dividend, req_divisor, rsp_ready,
        input  req_ready, rsp_valid, rsp_quotient, rsp_remainder, rsp_id, rsp_divzero
    );

    modport slave (
        input  req_valid, req_dividend, req_divisor, rsp_ready,
        output req_ready, rsp_valid, rsp_quotient, rsp_remainder, rsp_id, rsp_divzero
    );
endinterface

// File: rtl/shared_div_scheduler.sv
// Round-robin arbiter in front of one restoring unsigned divider (one quotient bit per cycle).
// Define SHDIV_PERF_CNT_EN to build the completed-operation counter on op_count.
module shared_div_scheduler #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    shared_div_scheduler_if.slave  bus,
    output logic                   busy,
    output logic [15:0]            op_count
);
    localparam int IDW  = $clog2(NREQ);
    localparam int CNTW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

    state_t           state, state_nxt;
    logic [IDW-1:0]   rr_ptr;
    logic [IDW-1:0]   grant_id;
    logic             found;
    logic             accept;
    logic [CNTW-1:0]  cnt;
    logic [WIDTH-1:0] sel_dividend;
    logic [WIDTH-1:0] sel_divisor;

    logic [WIDTH-1:0] quot_r;
    logic [WIDTH:0]   rem_r;
    logic [WIDTH-1:0] div_r;
    logic [IDW-1:0]   id_r;
    logic             dz_r;
    logic [WIDTH+1:0] trial;
    logic [WIDTH+1:0] sub;

    // First valid requester at or after rr_ptr, wrapping at NREQ-1.
    always_comb begin
        int j;
        j        = 0;
        found    = 1'b0;
        grant_id = '0;
        for (int k = 0; k < NREQ; k++) begin
            j = int'(rr_ptr) + k;
            if (j >= NREQ) j = j - NREQ;
            if (!found && bus.req_valid[j]) begin
                found    = 1'b1;
                grant_id = IDW'(j);
            end
        end
    end

    assign sel_dividend = bus.req_dividend[grant_id*WIDTH +: WIDTH];
    assign sel_divisor  = bus.req_divisor[grant_id*WIDTH +: WIDTH];
    assign accept       = (state == IDLE) && found;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        bus.req_ready = '0;
        case (state)
            IDLE: begin
                if (found) begin
                    bus.req_ready[grant_id] = 1'b1;
                    state_nxt = (sel_divisor == '0) ? DONE : DIV;
                end
            end
            DIV:     if (cnt == CNTW'(WIDTH-1)) state_nxt = DONE;
            DONE:    if (bus.rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (accept)
                rr_ptr <= (grant_id == IDW'(NREQ-1)) ? '0 : IDW'(grant_id + 1'b1);
            if (state == DIV) cnt <= cnt + 1'b1;
            else              cnt <= '0;
        end
    end

    // Restoring step: the sign bit of trial-divisor decides the quotient bit and whether to restore.
    assign trial = {rem_r, quot_r[WIDTH-1]};
    assign sub   = trial - {2'b00, div_r};

    always_ff @(posedge clk) begin
        if (accept) begin
            id_r  <= grant_id;
            div_r <= sel_divisor;
            if (sel_divisor == '0) begin
                quot_r <= '1;
                rem_r  <= {1'b0, sel_dividend};
                dz_r   <= 1'b1;
            end else begin
                quot_r <= sel_dividend;
                rem_r  <= '0;
                dz_r   <= 1'b0;
            end
        end else if (state == DIV) begin
            quot_r <= {quot_r[WIDTH-2:0], ~sub[WIDTH+1]};
            rem_r  <= sub[WIDTH+1] ? trial[WIDTH:0] : sub[WIDTH:0];
        end
    end

    assign busy              = (state != IDLE);
    assign bus.rsp_valid     = (state == DONE);
    assign bus.rsp_quotient  = bus.rsp_valid ? quot_r : '0;
    assign bus.rsp_remainder = bus.rsp_valid ? rem_r[WIDTH-1:0] : '0;
    assign bus.rsp_id        = bus.rsp_valid ? id_r : '0;
    assign bus.rsp_divzero   = bus.rsp_valid & dz_r;

`ifdef SHDIV_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst)                                op_count <= '0;
        else if (bus.rsp_valid && bus.rsp_ready) op_count <= op_count + 16'd1;
    end
`else
    assign op_count = '0;
`endif
endmodule
